// File: rtl/v30mz_divider.sv
// rtl/v30mz_divider.sv - multi-cycle restoring divider for DIV/DIVU, byte and word forms
module v30mz_divider #(
  parameter int ALLOW_MIN_QUOTIENT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        size,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_error,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic        size_r, signed_r, sign_q, sign_r, big;
  logic [15:0] rem, dvd, dvs;
  logic [4:0]  cnt;

  logic        dvd_neg, dvs_neg, hi_ge, early_err;
  logic [31:0] dvd_ext, dvd_sx, dvd_abs;
  logic [15:0] dvs_ext, dvs_sx, dvs_abs, hi_abs, lo_abs;

  logic        dmsb, no_borrow;
  logic [17:0] shifted, trial;
  logic [15:0] rem_next, dvd_next, mask_r;

  logic [15:0] half, q_fix, r_fix;
  logic        ovf;

  // Operand conditioning at start: magnitudes and signs for the selected width.
  always_comb begin
    dvd_neg   = signed_op & (size ? dividend[31] : dividend[15]);
    dvs_neg   = signed_op & (size ? divisor[15] : divisor[7]);
    dvd_ext   = size ? dividend : {16'h0000, dividend[15:0]};
    dvd_sx    = size ? dividend : {{16{dividend[15]}}, dividend[15:0]};
    dvd_abs   = dvd_neg ? (32'd0 - dvd_sx) : dvd_ext;
    dvs_ext   = size ? divisor : {8'h00, divisor[7:0]};
    dvs_sx    = size ? divisor : {{8{divisor[7]}}, divisor[7:0]};
    dvs_abs   = dvs_neg ? (16'd0 - dvs_sx) : dvs_ext;
    hi_abs    = size ? dvd_abs[31:16] : {8'h00, dvd_abs[15:8]};
    lo_abs    = size ? dvd_abs[15:0]  : {8'h00, dvd_abs[7:0]};
    hi_ge     = (hi_abs >= dvs_abs);
    early_err = (dvs_abs == 16'd0) | (~signed_op & hi_ge);
  end

  // One restoring step: shift {rem, dvd} left, trial-subtract the divisor.
  always_comb begin
    mask_r    = size_r ? 16'hFFFF : 16'h00FF;
    dmsb      = size_r ? dvd[15] : dvd[7];
    shifted   = size_r ? {1'b0, rem, dmsb} : {9'h000, rem[7:0], dmsb};
    trial     = shifted - {2'b00, dvs};
    no_borrow = ~trial[17];
    rem_next  = no_borrow ? trial[15:0] : shifted[15:0];
    dvd_next  = {dvd[14:0], no_borrow} & mask_r;
  end

  // Sign fix-up and signed overflow detection; big marks a quotient wider than N bits.
  always_comb begin
    half  = size_r ? 16'h8000 : 16'h0080;
    q_fix = (sign_q ? (16'd0 - dvd) : dvd) & mask_r;
    r_fix = (sign_r ? (16'd0 - rem) : rem) & mask_r;
    ovf   = signed_r & (big
                        | (~sign_q & (dvd > (half - 16'd1)))
                        | ( sign_q & (dvd > half))
                        | ((ALLOW_MIN_QUOTIENT == 0) & (dvd == half)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !early_err) state_next = CALC;
      CALC:    if (cnt == 5'd1) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_r    <= 1'b0;
      signed_r  <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      big       <= 1'b0;
      rem       <= 16'h0000;
      dvd       <= 16'h0000;
      dvs       <= 16'h0000;
      cnt       <= 5'd0;
      done      <= 1'b0;
      div_error <= 1'b0;
      quotient  <= 16'h0000;
      remainder <= 16'h0000;
    end else begin
      done      <= 1'b0;
      div_error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            size_r   <= size;
            signed_r <= signed_op;
            sign_q   <= dvd_neg ^ dvs_neg;
            sign_r   <= dvd_neg;
            if (early_err) begin
              done      <= 1'b1;
              div_error <= 1'b1;
              quotient  <= 16'h0000;
              remainder <= 16'h0000;
            end else begin
              rem <= hi_abs;
              dvd <= lo_abs;
              dvs <= dvs_abs;
              big <= signed_op & hi_ge;
              cnt <= size ? 5'd16 : 5'd8;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          dvd <= dvd_next;
          cnt <= cnt - 5'd1;
        end
        FIX: begin
          done      <= 1'b1;
          div_error <= ovf;
          quotient  <= ovf ? 16'h0000 : q_fix;
          remainder <= ovf ? 16'h0000 : r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_v30mz_divider.sv
// tb/tb_v30mz_divider.sv - scoreboard bench for v30mz_divider, both quotient-limit settings
module tb_v30mz_divider;

  logic        clk = 1'b0;
  logic        reset_n, start, size, signed_op;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, div_error;
  logic [15:0] quotient, remainder;
  logic        busy0, done0, div_error0;
  logic [15:0] quotient0, remainder0;

  always #5 clk = ~clk;

  v30mz_divider #(.ALLOW_MIN_QUOTIENT(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .div_error(div_error), .quotient(quotient), .remainder(remainder)
  );

  v30mz_divider #(.ALLOW_MIN_QUOTIENT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy0), .done(done0),
    .div_error(div_error0), .quotient(quotient0), .remainder(remainder0)
  );

  typedef struct {
    logic [15:0] q, r, q0, r0;
    logic        err, err0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: native truncating division on wide integers.
  function automatic void model(input logic sz, input logic sg, input logic [31:0] a_in,
                                input logic [15:0] b_in, input bit allow,
                                output logic [15:0] q_o, output logic [15:0] r_o,
                                output logic e_o, output int lat);
    int n;
    longint a, b, q, r, maxp;
    logic [15:0] a16;
    logic [7:0]  b8;
    logic [15:0] mask;
    n = sz ? 16 : 8;
    a16 = a_in[15:0];
    b8  = b_in[7:0];
    if (sz) begin
      a = sg ? longint'($signed(a_in)) : longint'(a_in);
      b = sg ? longint'($signed(b_in)) : longint'(b_in);
    end else begin
      a = sg ? longint'($signed(a16)) : longint'(a16);
      b = sg ? longint'($signed(b8)) : longint'(b8);
    end
    lat = n + 2;
    e_o = 1'b0;
    q = 0;
    r = 0;
    if (b == 0 || (!sg && ((a >> n) >= b))) begin
      e_o = 1'b1;
      lat = 1;
    end else begin
      q = a / b;
      r = a % b;
      maxp = (longint'(1) << (n - 1)) - 1;
      if (sg && (q > maxp || q < -maxp - 1 || (!allow && q == -maxp - 1))) begin
        e_o = 1'b1;
        q = 0;
        r = 0;
      end
    end
    mask = sz ? 16'hFFFF : 16'h00FF;
    q_o = q[15:0] & mask;
    r_o = r[15:0] & mask;
  endfunction

  task automatic start_op(input logic sz, input logic sg, input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    int l0;
    size = sz;
    signed_op = sg;
    dividend = a;
    divisor = b;
    start = 1'b1;
    model(sz, sg, a, b, 1'b1, e.q, e.r, e.err, e.lat);
    model(sz, sg, a, b, 1'b0, e.q0, e.r0, e.err0, l0);
    sb.push_back(e);
  endtask

  // Called at the negedge where start is driven; inj injects a stray start at that cycle.
  task automatic wait_done(input string tag, input int inj);
    exp_t e;
    int lat, bc;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    bc = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      chk({tag, ".err_idle"}, div_error, 1'b0);
      if (busy) bc++;
      if (lat == inj) begin
        start = 1'b1;
        dividend = 32'h0000_0123;
        divisor = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".done"}, done, 1'b1);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".lat"}, lat, e.lat);
      chk({tag, ".busy_cycles"}, bc, e.lat - 1);
      chk({tag, ".busy_at_done"}, busy, 1'b0);
      chk({tag, ".q"}, quotient, e.q);
      chk({tag, ".r"}, remainder, e.r);
      chk({tag, ".err"}, div_error, e.err);
      chk({tag, ".done0"}, done0, 1'b1);
      chk({tag, ".q0"}, quotient0, e.q0);
      chk({tag, ".r0"}, remainder0, e.r0);
      chk({tag, ".err0"}, div_error0, e.err0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    size = 1'b0;
    signed_op = 1'b0;
    dividend = 32'h0;
    divisor = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.err", div_error, 1'b0);
    chk("rst.q", quotient, 16'h0);
    chk("rst.r", remainder, 16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    start_op(1'b1, 1'b0, 32'h0001_0000, 16'h0003);
    wait_done("word_divu", 0);
    chk("word_divu.q_const", quotient, 16'h5555);
    chk("word_divu.r_const", remainder, 16'h0001);
    start_op(1'b0, 1'b1, 32'h0000_FF8B, 16'h0007);
    wait_done("byte_div", 0);
    chk("byte_div.q_const", quotient, 16'h00F0);
    chk("byte_div.r_const", remainder, 16'h00FB);
    start_op(1'b1, 1'b0, 32'h0000_1234, 16'h0000);
    wait_done("word_div0", 0);
    start_op(1'b0, 1'b0, 32'h0000_0400, 16'h0002);
    wait_done("byte_ovf", 0);
    start_op(1'b1, 1'b1, 32'hFFFF_8000, 16'h0001);
    wait_done("wmin_ok", 0);
    chk("wmin_ok.q_const", quotient, 16'h8000);
    start_op(1'b1, 1'b1, 32'h0000_8000, 16'h0001);
    wait_done("wpos_ovf", 0);
    start_op(1'b0, 1'b1, 32'h0000_FFF9, 16'h0002);
    wait_done("neg_pos", 0);
    start_op(1'b0, 1'b1, 32'h0000_0007, 16'h00FE);
    wait_done("pos_neg", 0);
    start_op(1'b0, 1'b1, 32'h0000_FFF9, 16'h00FE);
    wait_done("neg_neg", 0);
    chk("neg_neg.q_const", quotient, 16'h0003);
    chk("neg_neg.r_const", remainder, 16'h00FF);
    start_op(1'b0, 1'b0, 32'hABCD_0064, 16'h3307);
    wait_done("byte_upper_ignored", 0);
    start_op(1'b0, 1'b1, 32'h0000_FF80, 16'h0001);
    wait_done("bmin", 0);
    start_op(1'b0, 1'b1, 32'h0000_FF80, 16'h00FF);
    wait_done("bmin_neg1", 0);
    start_op(1'b1, 1'b1, 32'h0002_0000, 16'h0001);
    wait_done("wbig", 0);
    start_op(1'b0, 1'b1, 32'h0000_0055, 16'h0000);
    wait_done("sdiv0", 0);

    start_op(1'b1, 1'b0, 32'h0002_0000, 16'h0007);
    wait_done("busy_start", 4);

    start_op(1'b1, 1'b0, 32'h0001_2345, 16'h0100);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid.busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst.busy", busy, 1'b0);
    chk("mid_rst.done", done, 1'b0);
    chk("mid_rst.err", div_error, 1'b0);
    chk("mid_rst.q", quotient, 16'h0);
    chk("mid_rst.r", remainder, 16'h0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_op(1'b1, 1'b0, 32'h0001_2345, 16'h0100);
    wait_done("after_rst", 0);

    start_op(1'b0, 1'b1, 32'h0000_FFF9, 16'h0002);
    wait_done("b2b_a", 0);
    start_op(1'b1, 1'b1, 32'hFFFE_7960, 16'd300);
    wait_done("b2b_b", 0);
    repeat (3) @(negedge clk);
    chk("hold.done", done, 1'b0);
    chk("hold.q", quotient, 16'hFEB3);
    chk("hold.r", remainder, 16'hFF9C);

    for (int i = 0; i < 10; i++) begin
      start_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom >> $urandom_range(0, 24), 16'($urandom >> $urandom_range(0, 12)));
      wait_done("rnd", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
